// File: rtl/srsc_power_lut_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : srsc_power_lut_stage
// Purpose  : Operand feeder for the saturation-correction multipliers.
//            For every RGB pixel Jc it emits, per channel, the pair
//            x1 = Ac^0.3 (atmospheric light, held per frame) and
//            x2 = Jc^0.7 (per pixel). Both operands are unsigned Q8.8.
//            Two pipeline registers (S1 capture, S2 ROM read) sit between
//            the valid/ready input and the valid/ready output.
// Ports    : clk                  rising-edge clock
//            rst                  asynchronous reset, active low
//            ac_load / ac_in      strobe + {A_R,A_G,A_B} atmospheric light
//            in_valid / in_ready  pixel handshake, in_pix = {J_R,J_G,J_B}
//            out_valid / out_ready operand-set handshake
//            x1_r/g/b             Ac^0.3 per channel, Q8.8
//            x2_r/g/b             Jc^0.7 per channel, Q8.8
// Revision : 1.0 - initial release
// ============================================================================
module srsc_power_lut_stage #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ac_load,
  input  logic [3*PIX_W-1:0]   ac_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*PIX_W-1:0]   in_pix,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          x1_r,
  output logic [15:0]          x1_g,
  output logic [15:0]          x1_b,
  output logic [15:0]          x2_r,
  output logic [15:0]          x2_g,
  output logic [15:0]          x2_b
);

  typedef logic [255:0][15:0] lut_t;

  // v^10, operands stay below 2^15 so the result fits in 150 bits.
  function automatic logic [159:0] pow10(input logic [159:0] v);
    logic [159:0] v2;
    logic [159:0] v5;
    v2 = v * v;
    v5 = v2 * v2 * v;
    return v5 * v5;
  endfunction

  // Builds round(x^(expo/10) * 2^FRAC_W) exactly in integer arithmetic:
  // the entry is the largest y with (2y-1)^10 <= x^expo * 2^(10*(FRAC_W+1)),
  // i.e. (y-0.5)^10 <= (x^(expo/10) * 2^FRAC_W)^10. Evaluated at elaboration
  // only, so the ROM contents are plain constants.
  function automatic lut_t gen_lut(input int unsigned expo);
    lut_t         tbl;
    logic [159:0] tgt;
    int unsigned  lo;
    int unsigned  hi;
    int unsigned  mid;
    tbl = '0;
    for (int unsigned x = 1; x < 256; x++) begin
      tgt = 160'd1 << (10 * (FRAC_W + 1));
      for (int unsigned k = 0; k < expo; k++) begin
        tgt = tgt * 160'(x);
      end
      lo = 1;
      hi = 16383;
      while (lo < hi) begin
        mid = (lo + hi + 1) / 2;
        if (pow10(160'(2 * mid - 1)) <= tgt) lo = mid;
        else                                  hi = mid - 1;
      end
      tbl[x[7:0]] = lo[15:0];
    end
    return tbl;
  endfunction

  localparam lut_t c_jlut = gen_lut(7);   // Jc^0.7
  localparam lut_t c_alut = gen_lut(3);   // Ac^0.3

  localparam logic [1:0] c_st_noac  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_run   = 2'd2;
  localparam logic [1:0] c_st_drain = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          r_ld_cnt;
  logic [3*PIX_W-1:0]  r_ac_shadow;
  logic [15:0]         r_ac_r;
  logic [15:0]         r_ac_g;
  logic [15:0]         r_ac_b;
  logic                r_s1_valid;
  logic [3*PIX_W-1:0]  r_s1_pix;

  logic w_advance;
  logic w_accept;
  logic w_busy;

  // Whole pipeline moves together; it only stalls on a held output.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance && (r_state == c_st_run);
  assign w_accept  = in_valid && in_ready;
  // A pixel accepted this very cycle counts as in flight, so a same-cycle
  // ac_load must drain it with the old Ac before reloading.
  assign w_busy    = r_s1_valid || out_valid || w_accept;

  // Control FSM and atmospheric-light registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_st_noac;
      r_ld_cnt    <= 2'd0;
      r_ac_shadow <= '0;
      r_ac_r      <= '0;
      r_ac_g      <= '0;
      r_ac_b      <= '0;
    end else begin
      if (ac_load) r_ac_shadow <= ac_in;
      case (r_state)
        c_st_noac: begin
          if (ac_load) begin
            r_state  <= c_st_load;
            r_ld_cnt <= 2'd0;
          end
        end
        c_st_load: begin
          if (ac_load) begin
            // Newer strobe wins: restart the lookup from the red channel.
            r_ld_cnt <= 2'd0;
          end else begin
            case (r_ld_cnt)
              2'd0:    r_ac_r <= c_alut[r_ac_shadow[3*PIX_W-1 -: PIX_W]];
              2'd1:    r_ac_g <= c_alut[r_ac_shadow[2*PIX_W-1 -: PIX_W]];
              default: r_ac_b <= c_alut[r_ac_shadow[PIX_W-1 -: PIX_W]];
            endcase
            if (r_ld_cnt == 2'd2) r_state <= c_st_run;
            else                  r_ld_cnt <= r_ld_cnt + 2'd1;
          end
        end
        c_st_run: begin
          if (ac_load) begin
            r_state  <= w_busy ? c_st_drain : c_st_load;
            r_ld_cnt <= 2'd0;
          end
        end
        default: begin // c_st_drain
          if (!r_s1_valid && !out_valid) begin
            r_state  <= c_st_load;
            r_ld_cnt <= 2'd0;
          end
        end
      endcase
    end
  end

  // Datapath: S1 captures the pixel, S2 is the registered ROM read. The Ac
  // registers are copied alongside; they never change while data is in
  // flight because LOAD is only entered with an empty pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      out_valid  <= 1'b0;
      x1_r       <= '0;
      x1_g       <= '0;
      x1_b       <= '0;
      x2_r       <= '0;
      x2_g       <= '0;
      x2_b       <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_pix <= in_pix;
      out_valid  <= r_s1_valid;
      if (r_s1_valid) begin
        x1_r <= r_ac_r;
        x1_g <= r_ac_g;
        x1_b <= r_ac_b;
        x2_r <= c_jlut[r_s1_pix[3*PIX_W-1 -: PIX_W]];
        x2_g <= c_jlut[r_s1_pix[2*PIX_W-1 -: PIX_W]];
        x2_b <= c_jlut[r_s1_pix[PIX_W-1 -: PIX_W]];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srsc_power_lut_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_srsc_power_lut_stage
// Purpose  : Directed self-checking bench for srsc_power_lut_stage.
//            Expected Jc^0.7 values come from a floating-point model; the
//            Ac^0.3 values used (1097, 256, 0) and JLUT[255]=12383 are
//            hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srsc_power_lut_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ac_load;
  logic [23:0] ac_in;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pix;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x1_r, x1_g, x1_b, x2_r, x2_g, x2_b;
  logic [95:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  logic [95:0] sb_q[$];

  always #5 clk = ~clk;

  assign obs = {x1_r, x1_g, x1_b, x2_r, x2_g, x2_b};

  srsc_power_lut_stage #(.PIX_W(8), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst), .ac_load(ac_load), .ac_in(ac_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready),
    .x1_r(x1_r), .x1_g(x1_g), .x1_b(x1_b),
    .x2_r(x2_r), .x2_g(x2_g), .x2_b(x2_b)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int jm(input int x);
    return $rtoi($pow(real'(x), 0.7) * 256.0 + 0.5);
  endfunction

  function automatic logic [95:0] exp_set(input logic [47:0] x1, input logic [23:0] p);
    return {x1, 16'(jm(int'(p[23:16]))), 16'(jm(int'(p[15:8]))), 16'(jm(int'(p[7:0])))};
  endfunction

  task automatic wait_ready(input string tag, output int waited);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check(tag, 96'(in_ready), 96'(1));
  endtask

  task automatic wait_valid(input string tag);
    int waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check(tag, 96'(out_valid), 96'(1));
  endtask

  task automatic load_ac(input logic [23:0] a, input string tag);
    int w;
    @(negedge clk);
    ac_load = 1'b1; ac_in = a;
    @(negedge clk);
    ac_load = 1'b0; #1;
    wait_ready(tag, w);
  endtask

  // Streams n pixels {i,i,i} (i = base..) with an optional out_ready gap,
  // scoreboarding every output and checking stall behaviour.
  task automatic run_stream(input int n, input int base, input int stall_at,
                            input int stall_len, input logic [47:0] x1, output int cycles);
    int          sent = 0;
    int          rcv = 0;
    logic        prev_stall = 1'b0;
    logic [95:0] prev_obs = '0;
    logic [95:0] e;
    logic [23:0] p;
    cycles = 0;
    while (rcv < n && cycles < 2000) begin
      @(negedge clk);
      out_ready = !(cycles >= stall_at && cycles < stall_at + stall_len);
      p = {3{8'(base + sent)}};
      in_valid = (sent < n);
      in_pix = p;
      #1;
      if (prev_stall) begin
        check("stall_hold", obs, prev_obs);
        check("stall_valid", 96'(out_valid), 96'(1));
      end
      if (out_valid && !out_ready) check("stall_ready", 96'(in_ready), 96'(0));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("spurious_out", 96'(sb_q.size()), 96'(1));
        else begin
          e = sb_q.pop_front();
          check("stream_data", obs, e);
        end
        rcv++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(exp_set(x1, p));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 96'(rcv), 96'(n));
    check("stream_left", 96'(sb_q.size()), 96'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    int cyc;
    int bad;
    rst = 1'b0; ac_load = 1'b0; ac_in = '0;
    in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 96'(out_valid), 96'(0));
    check("rst_in_ready", 96'(in_ready), 96'(0));
    check("rst_outputs", obs, 96'(0));
    @(negedge clk);
    rst = 1'b1;

    // No Ac loaded: nothing may be accepted or produced.
    in_valid = 1'b1; in_pix = 24'h111111; bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (in_ready || out_valid) bad++;
    end
    check("noac_idle", 96'(bad), 96'(0));
    in_valid = 1'b0;

    // First Ac load and a single pixel.
    @(negedge clk);
    ac_load = 1'b1; ac_in = 24'h800080;
    @(negedge clk);
    ac_load = 1'b0; #1;
    wait_ready("load_ready", w);
    check("load_lat", 96'(w), 96'(3));
    in_valid = 1'b1; in_pix = 24'h800001;
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("lat_early", 96'(out_valid), 96'(0));
    @(negedge clk); #1;
    check("lat_valid", 96'(out_valid), 96'(1));
    check("first_pix", obs, {16'd1097, 16'd0, 16'd1097, 16'd7643, 16'd0, 16'd256});

    // Full sweep of JLUT at one pixel per cycle.
    run_stream(256, 0, -1, 0, {16'd1097, 16'd0, 16'd1097}, cyc);
    check("sweep_cycles", 96'(cyc), 96'(258));

    // Backpressure mid-stream.
    run_stream(20, 100, 6, 5, {16'd1097, 16'd0, 16'd1097}, cyc);

    // ac_load coinciding with a pixel accept.
    load_ac(24'h808080, "reload_ready");
    ac_load = 1'b1; ac_in = 24'h010101;
    in_valid = 1'b1; in_pix = 24'h40C0FF;
    #1;
    check("same_cycle_ready", 96'(in_ready), 96'(1));
    @(negedge clk);
    ac_load = 1'b0; in_valid = 1'b0; #1;
    check("drain_block", 96'(in_ready), 96'(0));
    wait_valid("old_ac_valid");
    check("old_ac_pix", obs, exp_set({3{16'd1097}}, 24'h40C0FF));
    @(negedge clk); #1;
    wait_ready("new_ac_ready", w);
    in_valid = 1'b1; in_pix = 24'h02FF80;
    @(negedge clk);
    in_valid = 1'b0; #1;
    wait_valid("new_ac_valid");
    check("new_ac_pix", obs, exp_set({3{16'd256}}, 24'h02FF80));

    // Reset with two pixels in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_pix = 24'h0A0B0C;
    @(negedge clk);
    in_pix = 24'h0D0E0F;
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("inflight_valid", 96'(out_valid), 96'(1));
    rst = 1'b0; #1;
    check("async_rst_valid", 96'(out_valid), 96'(0));
    check("async_rst_ready", 96'(in_ready), 96'(0));
    check("async_rst_outs", obs, 96'(0));
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_pix = 24'h333333; bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (in_ready || out_valid) bad++;
    end
    check("post_rst_noac", 96'(bad), 96'(0));
    in_valid = 1'b0;
    load_ac(24'h808080, "post_rst_ready");
    in_valid = 1'b1; in_pix = 24'hFF0000;
    @(negedge clk);
    in_valid = 1'b0; #1;
    wait_valid("post_rst_valid");
    check("jlut_max", obs, {16'd1097, 16'd1097, 16'd1097, 16'd12383, 16'd0, 16'd0});

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
